// File: rtl/cbus_pkg.sv
// Shared definitions for the common-bus transfer block.
//   xferState_e : transfer FSM state encoding
//   WIDTH_DEF   : default register / bus width
//   IDX_A..D    : register index codes used on xfer_src/xfer_dst/ext_dst
package cbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } xferState_e;

  localparam int unsigned WIDTH_DEF = 4;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

endpackage

// File: rtl/cbus_xfer_if.sv
// Transfer handshake and common-bus signals.
//   master : requester side (drives xfer_req/src/dst, returns busIn from the mux)
//   slave  : cbus_xfer side (drives muxSelect, xfer_busy, xfer_done)
interface cbus_xfer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             xfer_req;
  logic [1:0]       xfer_src;
  logic [1:0]       xfer_dst;
  logic [WIDTH-1:0] busIn;
  logic [1:0]       muxSelect;
  logic             xfer_busy;
  logic             xfer_done;

  modport master (
    output xfer_req, xfer_src, xfer_dst, busIn,
    input  muxSelect, xfer_busy, xfer_done
  );

  modport slave (
    input  xfer_req, xfer_src, xfer_dst, busIn,
    output muxSelect, xfer_busy, xfer_done
  );
endinterface

// File: rtl/cbus_dec2to4.sv
// 2-to-4 decoder with enable: produces one-hot register load enables.
//   idx    : register index
//   en     : decode enable; all outputs low when 0
//   onehot : one-hot load enables, bit n for register index n
module cbus_dec2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/cbus_xfer.sv
// Register-to-register transfer over a common bus with external parallel load.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : xfer_req/src/dst in, busIn from external mux,
//                         muxSelect/xfer_busy/xfer_done out
//   ext_load/dst/data   : external write into one register, any state
//   regA..regD          : register contents, feeding the bus multiplexer
module cbus_xfer
  import cbus_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cbus_xfer_if.slave       bus,
  input  logic             ext_load,
  input  logic [1:0]       ext_dst,
  input  logic [WIDTH-1:0] ext_data,
  output logic [WIDTH-1:0] regA,
  output logic [WIDTH-1:0] regB,
  output logic [WIDTH-1:0] regC,
  output logic [WIDTH-1:0] regD
);

  xferState_e       state;
  logic [1:0]       srcLat;
  logic [1:0]       dstLat;
  logic [1:0]       muxSel;
  logic             busy;
  logic             done;
  logic [3:0]       busWe;
  logic [3:0]       extWe;
  logic [WIDTH-1:0] regs [4];

  // muxSelect is loaded on entry to SEL and otherwise held, so it tracks the
  // latched source through SEL/LOAD and keeps its last value elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      srcLat <= '0;
      dstLat <= '0;
      muxSel <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.xfer_req) begin
            state  <= SEL;
            srcLat <= bus.xfer_src;
            dstLat <= bus.xfer_dst;
            muxSel <= bus.xfer_src;
            busy   <= 1'b1;
          end
          done <= 1'b0;
        end
        SEL: begin
          state <= LOAD;
          muxSel <= srcLat;
        end
        LOAD: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cbus_dec2to4 u_busDec (
    .idx    (dstLat),
    .en     (state == LOAD),
    .onehot (busWe)
  );

  cbus_dec2to4 u_extDec (
    .idx    (ext_dst),
    .en     (ext_load),
    .onehot (extWe)
  );

  // Bus write is checked first so it wins over an external write to the
  // same register in the LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (busWe[i])      regs[i] <= bus.busIn;
        else if (extWe[i]) regs[i] <= ext_data;
      end
    end
  end

  assign bus.muxSelect = muxSel;
  assign bus.xfer_busy = busy;
  assign bus.xfer_done = done;

  assign regA = regs[IDX_A];
  assign regB = regs[IDX_B];
  assign regC = regs[IDX_C];
  assign regD = regs[IDX_D];

endmodule

// File: tb/tb_cbus_xfer.sv
module tb_cbus_xfer;
  import cbus_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ext_load;
  logic [1:0]   ext_dst;
  logic [W-1:0] ext_data;
  logic [W-1:0] regA, regB, regC, regD;

  int compared = 0;
  int mismatched = 0;

  cbus_xfer_if #(.WIDTH(W)) bus ();

  cbus_xfer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ext_load (ext_load),
    .ext_dst  (ext_dst),
    .ext_data (ext_data),
    .regA     (regA),
    .regB     (regB),
    .regC     (regC),
    .regD     (regD)
  );

  // existing 4:1 bus multiplexer closing the loop
  assign bus.busIn = (bus.muxSelect == IDX_A) ? regA :
                     (bus.muxSelect == IDX_B) ? regB :
                     (bus.muxSelect == IDX_C) ? regC : regD;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic extWrite(input logic [1:0] dst, input logic [W-1:0] data);
    ext_load = 1'b1;
    ext_dst  = dst;
    ext_data = data;
    tick();
    ext_load = 1'b0;
  endtask

  logic [7:0] busyVec;
  int doneTicks[$];

  initial begin
    rst_n = 1'b0;
    ext_load = 1'b0;
    ext_dst = '0;
    ext_data = '0;
    bus.xfer_req = 1'b0;
    bus.xfer_src = '0;
    bus.xfer_dst = '0;
    #2;
    check("rst_regs", {regA, regB, regC, regD}, 16'h0000);
    check("rst_mux", bus.muxSelect, 2'b00);
    check("rst_busy", bus.xfer_busy, 1'b0);
    check("rst_done", bus.xfer_done, 1'b0);
    tick();
    rst_n = 1'b1;

    // basic transfer A -> C
    extWrite(IDX_A, 4'h5);
    extWrite(IDX_B, 4'hA);
    check("ext_ab", {regA, regB}, 8'h5A);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_A; bus.xfer_dst = IDX_C;
    tick();
    bus.xfer_req = 1'b0;
    check("ac_c1_busy", bus.xfer_busy, 1'b1);
    check("ac_c1_mux", bus.muxSelect, 2'b00);
    check("ac_c1_done", bus.xfer_done, 1'b0);
    tick();
    check("ac_c2_mux", bus.muxSelect, 2'b00);
    check("ac_c2_regC", regC, 4'h0);
    tick();
    check("ac_c3_regC", regC, 4'h5);
    check("ac_c3_done", bus.xfer_done, 1'b1);
    tick();
    check("ac_c4_busy", bus.xfer_busy, 1'b0);
    check("ac_c4_done", bus.xfer_done, 1'b0);

    // self transfer B -> B
    extWrite(IDX_B, 4'h9);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_B; bus.xfer_dst = IDX_B;
    tick();
    bus.xfer_req = 1'b0;
    check("bb_mux", bus.muxSelect, 2'b01);
    doneTicks.delete();
    for (int i = 2; i <= 5; i++) begin
      tick();
      if (bus.xfer_done === 1'b1) doneTicks.push_back(i);
    end
    check("bb_regB", regB, 4'h9);
    check("bb_done_count", doneTicks.size(), 1);

    // held request D -> A for 8 cycles
    extWrite(IDX_D, 4'h7);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_D; bus.xfer_dst = IDX_A;
    doneTicks.delete();
    busyVec = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      busyVec[i-1] = bus.xfer_busy;
      if (bus.xfer_done === 1'b1) doneTicks.push_back(i);
    end
    bus.xfer_req = 1'b0;
    check("held_done_count", doneTicks.size(), 2);
    if (doneTicks.size() == 2) begin
      check("held_first_done", doneTicks[0], 3);
      check("held_spacing", doneTicks[1] - doneTicks[0], 4);
    end
    check("held_busy_vec", busyVec, 8'b0111_0111);
    check("held_regA", regA, 4'h7);
    tick();
    check("held_idle", bus.xfer_busy, 1'b0);

    // bus write wins over ext write to the destination in LOAD
    extWrite(IDX_A, 4'h2);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_A; bus.xfer_dst = IDX_D;
    tick();
    bus.xfer_req = 1'b0;
    tick();
    ext_load = 1'b1; ext_dst = IDX_D; ext_data = 4'hF;
    tick();
    ext_load = 1'b0;
    check("ld_same_regD", regD, 4'h2);
    check("ld_same_done", bus.xfer_done, 1'b1);
    tick();

    // both writes land when indices differ
    extWrite(IDX_D, 4'h0);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_A; bus.xfer_dst = IDX_D;
    tick();
    bus.xfer_req = 1'b0;
    tick();
    ext_load = 1'b1; ext_dst = IDX_B; ext_data = 4'hF;
    tick();
    ext_load = 1'b0;
    check("ld_diff_regB", regB, 4'hF);
    check("ld_diff_regD", regD, 4'h2);
    tick();

    // ext write to source during SEL is what gets transferred
    extWrite(IDX_A, 4'h1);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_A; bus.xfer_dst = IDX_C;
    tick();
    bus.xfer_req = 1'b0;
    ext_load = 1'b1; ext_dst = IDX_A; ext_data = 4'h3;
    tick();
    ext_load = 1'b0;
    tick();
    check("sel_ext_regC", regC, 4'h3);
    check("sel_ext_done", bus.xfer_done, 1'b1);
    tick();

    // reset during LOAD aborts the transfer
    extWrite(IDX_B, 4'h6);
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_B; bus.xfer_dst = IDX_A;
    tick();
    bus.xfer_req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_regs", {regA, regB, regC, regD}, 16'h0000);
    check("abort_busy", bus.xfer_busy, 1'b0);
    check("abort_mux", bus.muxSelect, 2'b00);
    tick();
    rst_n = 1'b1;
    doneTicks.delete();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.xfer_done !== 1'b0) doneTicks.push_back(i);
    end
    check("abort_no_done", doneTicks.size(), 0);
    check("abort_regA", regA, 4'h0);

    // request accepted on first edge after reset release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.xfer_req = 1'b1; bus.xfer_src = IDX_C; bus.xfer_dst = IDX_B;
    tick();
    bus.xfer_req = 1'b0;
    check("first_req_busy", bus.xfer_busy, 1'b1);
    check("first_req_mux", bus.muxSelect, 2'b10);
    tick();
    tick();
    check("first_req_done", bus.xfer_done, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cbus_xfer.md
CBUS_XFER -- requirements
Module: cbus_xfer

Interface
REQ-001 Parameter: WIDTH, default 4, register and bus width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 xfer_req  input  1  request a register-to-register transfer over the common bus; sampled only in IDLE.
REQ-005 xfer_src  input  2  source register index (0=A, 1=B, 2=C, 3=D); sampled with xfer_req.
REQ-006 xfer_dst  input  2  destination register index, same encoding; sampled with xfer_req.
REQ-007 busIn  input  WIDTH  common bus value returned from the bus multiplexer.
REQ-008 muxSelect  output  2  bus multiplexer select driven to the bus multiplexer.
REQ-009 ext_load  input  1  external parallel load enable.
REQ-010 ext_dst  input  2  external load target index.
REQ-011 ext_data  input  WIDTH  external load data.
REQ-012 regA, regB, regC, regD  output  WIDTH each  register contents, fed to the bus multiplexer inputs.
REQ-013 xfer_busy  output  1  high while the FSM is not in IDLE.
REQ-014 xfer_done  output  1  one-cycle pulse marking transfer completion.

Function
REQ-015 The FSM SHALL have four states: IDLE, SEL, LOAD, DONE.
REQ-016 IDLE->SEL on a clk edge with xfer_req=1, latching xfer_src and xfer_dst; otherwise the FSM stays in IDLE.
REQ-017 SEL->LOAD, LOAD->DONE, DONE->IDLE SHALL be unconditional, one cycle each.
REQ-018 muxSelect SHALL equal the latched source in SEL and LOAD, and SHALL hold its last value in IDLE and DONE.
REQ-019 On the clk edge ending LOAD, the latched destination register SHALL capture busIn.
REQ-020 xfer_done SHALL be 1 exactly during DONE; data is visible on reg outputs in that same cycle; latency from the request edge to xfer_done high is 3 cycles.
REQ-021 xfer_req while xfer_busy=1 SHALL be ignored: no queueing and no error flag.
REQ-022 xfer_req held high in DONE SHALL start a new transfer only from IDLE, giving a minimum of 4 cycles per transfer.
REQ-023 xfer_src equal to xfer_dst SHALL be legal: the register reloads its own value, and done pulses normally.
REQ-024 ext_load=1 SHALL write ext_data into register ext_dst on that edge, in any state.
REQ-025 In the LOAD cycle with ext_load=1 and ext_dst equal to the latched destination, the bus value SHALL win; with different indices, both writes occur.
REQ-026 An ext_load to the source register during SEL SHALL be reflected in the value captured in LOAD.
REQ-027 Registers not addressed on an edge SHALL hold their value.

Reset
REQ-028 While rst_n=0: FSM in IDLE, regA..regD=0, muxSelect=2'b00, xfer_busy=0, xfer_done=0, latched indices=0; this takes effect immediately, independent of clk.
REQ-029 Reset mid-transfer SHALL abort the transfer: no destination write and no xfer_done pulse after release.
REQ-030 The first xfer_req SHALL be accepted on the first clk edge with rst_n=1.

Structure
REQ-031 Shared package cbus_pkg SHALL hold: the FSM state enum, the WIDTH default, and register index constants IDX_A..IDX_D.
REQ-032 One sub-module, cbus_dec2to4, SHALL decode a 2-bit index plus enable into four one-hot load enables; it is instantiated twice, once for the bus write and once for the external write.
REQ-033 The bench SHALL close the loop through the existing 4:1 bus multiplexer, with busIn driven by the multiplexer output.

Verification
REQ-034 Reset, then ext_load A=4'h5, B=4'hA; xfer_req src=A dst=C -> muxSelect=00 in SEL/LOAD, regC=4'h5 and xfer_done=1 on cycle 3, xfer_busy low on cycle 4.
REQ-035 Transfer src=B dst=B with regB=4'h9 -> regB stays 4'h9, xfer_done pulses once.
REQ-036 xfer_req src=D dst=A held high for 8 cycles -> exactly two transfers, with done pulses 4 cycles apart; requests while busy have no effect.
REQ-037 Transfer src=A dst=D with ext_load D=4'hF in the LOAD cycle -> regD = regA value; repeat with ext_load to B -> regB=4'hF and regD = regA value.
REQ-038 ext_load A=4'h3 in the SEL cycle of transfer A->C (A was 4'h1) -> regC=4'h3.
REQ-039 rst_n low in the LOAD state -> all registers 0 immediately, no xfer_done after release, FSM in IDLE and accepting requests.
